// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART transmit path
// Purpose: serializer state encoding and frame constants.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester-side byte handshake bundle
// Purpose: groups the per-requester valid/data/ready vectors.
// Ports (modports):
//   master - drives req_valid/req_data, observes req_ready (byte producers)
//   slave  - observes req_valid/req_data, drives req_ready (arbiter)
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;

  modport master (output req_valid, output req_data, input req_ready);
  modport slave  (input req_valid, input req_data, output req_ready);

endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - baud-timed 8N1 frame serializer
// Purpose: shifts one byte out as start bit, 8 data bits LSB first, stop bit.
// Ports:
//   clk, reset    - clock, asynchronous active-low reset
//   load          - accept load_data and begin a frame (honoured only when idle)
//   load_data     - byte to transmit
//   idle          - serializer is in IDLE and can accept a load
//   Tx            - registered serial line, idle high
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [UART_DATA_BITS-1:0] load_data,
  output logic                      idle,
  output logic                      Tx
);

  localparam int            CW      = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    BIT_MAX = 3'(UART_DATA_BITS - 1);

  uart_tx_state_t            state, state_n;
  logic [CW-1:0]             cnt, cnt_n;
  logic [2:0]                bit_idx, bit_n;
  logic [UART_DATA_BITS-1:0] shreg, shreg_n;
  logic                      tx_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      Tx      <= UART_IDLE_LEVEL;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_n;
      shreg   <= shreg_n;
      Tx      <= tx_n;
    end
  end

  // Tx is computed from the current state, so the line lags the state by
  // one clock; every bit therefore still lasts exactly CLKS_PER_BIT cycles.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shreg_n = shreg;
    tx_n    = UART_IDLE_LEVEL;
    case (state)
      IDLE: begin
        tx_n = UART_IDLE_LEVEL;
        if (load) begin
          shreg_n = load_data;
          cnt_n   = '0;
          bit_n   = '0;
          state_n = START;
        end
      end
      START: begin
        tx_n = 1'b0;
        if (cnt == CNT_MAX) begin
          cnt_n   = '0;
          state_n = DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        tx_n = shreg[0];
        if (cnt == CNT_MAX) begin
          cnt_n   = '0;
          shreg_n = {1'b0, shreg[UART_DATA_BITS-1:1]};
          if (bit_idx == BIT_MAX) begin
            bit_n   = '0;
            state_n = STOP;
          end else begin
            bit_n = bit_idx + 3'd1;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        tx_n = UART_IDLE_LEVEL;
        if (cnt == CNT_MAX) begin
          cnt_n   = '0;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign idle = (state == IDLE);

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one 8N1 UART transmitter
// Purpose: grants one requester per frame and feeds its byte to the serializer.
// Ports:
//   clk, reset - clock, asynchronous active-low reset
//   req        - slave side of the valid/data/ready requester bundle
//   Tx         - serial line, idle high
//   busy       - a frame is on the line
//   grant_id   - owner of the current or most recent frame
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  uart_tx_arbiter_if.slave           req,
  output logic                       Tx,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int SW = IW + 1;

  logic [IW-1:0]             rr_ptr, winner, idx;
  logic [SW-1:0]             sum;
  logic                      found, idle, load;
  logic [UART_DATA_BITS-1:0] load_data;

  // Search upward from rr_ptr; the sum never exceeds 2*NUM_REQ-2, so one
  // conditional subtract is enough to wrap it.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    sum    = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + SW'(k);
      if (sum >= SW'(NUM_REQ)) sum = sum - SW'(NUM_REQ);
      idx = sum[IW-1:0];
      if (!found && req.req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  // Held low during reset even though the serializer already reads IDLE.
  always_comb begin
    req.req_ready = '0;
    if (reset && idle && found) req.req_ready[winner] = 1'b1;
  end

  assign load = |(req.req_valid & req.req_ready);

  always_comb begin
    load_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (winner == IW'(k)) load_data = req.req_data[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr   <= '0;
      grant_id <= '0;
    end else if (load) begin
      grant_id <= winner;
      rr_ptr   <= (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

  uart_tx_serializer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_ser (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_data(load_data),
    .idle     (idle),
    .Tx       (Tx)
  );

  assign busy = ~idle;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N = 4;
  localparam int C = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx;
  logic       busy;
  logic [1:0] grant_id;
  int         tests = 0;
  int         fails = 0;
  int         w;
  logic [7:0] fair_bytes [4];
  int         fair_order [5];

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ     (N),
    .CLKS_PER_BIT(C)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (bus),
    .Tx      (tx),
    .busy    (busy),
    .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_byte(input int i, input logic [7:0] b);
    bus.req_data[8*i +: 8] = b;
  endtask

  // Waits (bounded) for a nonzero req_ready at a falling edge, checks it,
  // then steps to just after the handshake edge.
  task automatic wait_grant(input string tag, input logic [3:0] exp_ready, output int waited);
    waited = 0;
    while (bus.req_ready == 4'b0 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_ready"}, {28'b0, bus.req_ready}, {28'b0, exp_ready});
    @(posedge clk);
    #1;
  endtask

  // Called just after the handshake edge; checks every cycle of the frame
  // up to the first IDLE cycle. Optionally rewrites req_valid at cycle chg_m.
  task automatic check_frame(input string tag, input logic [7:0] b, input logic [1:0] gid,
                             input int chg_m, input logic [3:0] chg_val);
    logic exp_tx;
    for (int m = 0; m <= 10*C; m++) begin
      @(negedge clk);
      if (m == 0)          exp_tx = 1'b1;
      else if (m <= C)     exp_tx = 1'b0;
      else if (m <= 9*C)   exp_tx = b[(m-C-1)/C];
      else                 exp_tx = 1'b1;
      chk($sformatf("%s_tx_m%0d", tag, m), {31'b0, tx}, {31'b0, exp_tx});
      chk($sformatf("%s_busy_m%0d", tag, m), {31'b0, busy}, {31'b0, (m < 10*C)});
      chk($sformatf("%s_gid_m%0d", tag, m), {30'b0, grant_id}, {30'b0, gid});
      if (m < 10*C)
        chk($sformatf("%s_ready_m%0d", tag, m), {28'b0, bus.req_ready}, 32'h0);
      if (m == chg_m) bus.req_valid = chg_val;
    end
  endtask

  initial begin
    fair_bytes[0] = 8'h11; fair_bytes[1] = 8'h6C;
    fair_bytes[2] = 8'hD2; fair_bytes[3] = 8'h87;
    fair_order[0] = 0; fair_order[1] = 1; fair_order[2] = 2;
    fair_order[3] = 3; fair_order[4] = 0;

    // Reset state, with a request pending that must not be acknowledged
    reset         = 1'b0;
    bus.req_data  = '0;
    bus.req_valid = 4'b0001;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tx", {31'b0, tx}, 32'h1);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_ready", {28'b0, bus.req_ready}, 32'h0);
    chk("rst_gid", {30'b0, grant_id}, 32'h0);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    reset = 1'b1;

    // Single frame: requester 0 sends 0xA5
    set_byte(0, 8'hA5);
    bus.req_valid = 4'b0001;
    #1;
    wait_grant("single", 4'b0001, w);
    chk("single_wait", w, 0);
    bus.req_valid = 4'b0000;
    check_frame("single", 8'hA5, 2'd0, -1, 4'b0);
    chk("single_end_ready", {28'b0, bus.req_ready}, 32'h0);

    // Idle reset pulse returns the pointer to 0
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst2_tx", {31'b0, tx}, 32'h1);
    chk("rst2_gid", {30'b0, grant_id}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Fairness: all requesters valid for five frames
    for (int i = 0; i < 4; i++) set_byte(i, fair_bytes[i]);
    bus.req_valid = 4'b1111;
    #1;
    for (int f = 0; f < 5; f++) begin
      wait_grant($sformatf("fair%0d", f), 4'(1 << fair_order[f]), w);
      chk($sformatf("fair%0d_wait", f), w, 0);
      if (f == 4) bus.req_valid = 4'b0000;
      check_frame($sformatf("fair%0d", f), fair_bytes[fair_order[f]],
                  2'(fair_order[f]), -1, 4'b0);
    end

    // Wrap: grant 3, then only 2 valid, then pointer must sit at 3
    set_byte(3, 8'h5A);
    bus.req_valid = 4'b1000;
    #1;
    wait_grant("wrapA", 4'b1000, w);
    bus.req_valid = 4'b0000;
    check_frame("wrapA", 8'h5A, 2'd3, -1, 4'b0);
    set_byte(2, 8'h99);
    bus.req_valid = 4'b0100;
    #1;
    wait_grant("wrapB", 4'b0100, w);
    bus.req_valid = 4'b0000;
    check_frame("wrapB", 8'h99, 2'd2, -1, 4'b0);
    set_byte(0, 8'h01);
    set_byte(1, 8'h02);
    set_byte(3, 8'h44);
    bus.req_valid = 4'b1011;
    #1;
    wait_grant("wrapC", 4'b1000, w);
    bus.req_valid = 4'b0000;
    check_frame("wrapC", 8'h44, 2'd3, -1, 4'b0);

    // Back-to-back from requester 1: 0x00 then 0xFF, one idle cycle between
    set_byte(1, 8'h00);
    bus.req_valid = 4'b0010;
    #1;
    wait_grant("b2bA", 4'b0010, w);
    set_byte(1, 8'hFF);
    check_frame("b2bA", 8'h00, 2'd1, -1, 4'b0);
    wait_grant("b2bB", 4'b0010, w);
    chk("b2b_gap", w, 0);
    bus.req_valid = 4'b0000;
    check_frame("b2bB", 8'hFF, 2'd1, -1, 4'b0);

    // Retraction: pointer at 1 after this frame; requester 1 drops out
    // just before IDLE while requester 3 stays valid
    set_byte(0, 8'h3C);
    bus.req_valid = 4'b0001;
    #1;
    wait_grant("retA", 4'b0001, w);
    set_byte(3, 8'hE7);
    bus.req_valid = 4'b1010;
    check_frame("retA", 8'h3C, 2'd0, 10*C-1, 4'b1000);
    wait_grant("retB", 4'b1000, w);
    chk("ret_wait", w, 0);
    bus.req_valid = 4'b0000;
    check_frame("retB", 8'hE7, 2'd3, -1, 4'b0);

    // Reset in the middle of data bit 3 of 0x0F
    set_byte(0, 8'h0F);
    bus.req_valid = 4'b0001;
    #1;
    wait_grant("midrst", 4'b0001, w);
    bus.req_valid = 4'b0000;
    repeat (19) @(negedge clk);
    chk("midrst_pre_busy", {31'b0, busy}, 32'h1);
    chk("midrst_pre_tx", {31'b0, tx}, 32'h1);
    reset = 1'b0;
    set_byte(0, 8'h7E);
    set_byte(2, 8'h81);
    bus.req_valid = 4'b0101;
    #1;
    chk("midrst_tx", {31'b0, tx}, 32'h1);
    chk("midrst_busy", {31'b0, busy}, 32'h0);
    chk("midrst_gid", {30'b0, grant_id}, 32'h0);
    chk("midrst_ready", {28'b0, bus.req_ready}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    wait_grant("postrstA", 4'b0001, w);
    bus.req_valid = 4'b0100;
    check_frame("postrstA", 8'h7E, 2'd0, -1, 4'b0);
    wait_grant("postrstB", 4'b0100, w);
    chk("postrst_wait", w, 0);
    bus.req_valid = 4'b0000;
    check_frame("postrstB", 8'h81, 2'd2, -1, 4'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one 8N1 UART transmit line between `NUM_REQ` on-chip requesters. A round-robin arbiter grants one requester per frame, and an internal baud-timed serializer drives the line. The block sits between the byte producers and the `Tx` pin. It replaces per-client direct drive of the transmitter with a single sequenced owner.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `CLKS_PER_BIT`, default 16: `clk` cycles per UART bit, at least 2.

Ports:
- `clk`  in  1: the single clock; all logic is on the rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req_valid`  in  `NUM_REQ`: bit i high means requester i has a byte pending.
- `req_data`  in  `8*NUM_REQ`: byte i is at `[8*i+7:8*i]`.
- `req_ready`  out  `NUM_REQ`: one-hot acceptance strobe.
- `Tx`  out  1: serial line, idle high.
- `busy`  out  1: high while a frame is on the line.
- `grant_id`  out  `$clog2(NUM_REQ)`: index of the requester that owns the current or most recent frame.

## Operation
- FSM states: IDLE, START, DATA, STOP.
- Transition IDLE→START: on a handshake.
- Transition START→DATA: after `CLKS_PER_BIT` cycles.
- Transition DATA→STOP: after 8 bits.
- Transition STOP→IDLE: after `CLKS_PER_BIT` cycles.
- Arbitration (IDLE only):
  - Winner is the first i with `req_valid[i]`, searching from `rr_ptr` upward and wrapping modulo `NUM_REQ`.
  - `req_ready[winner]` is driven combinationally high in IDLE. All other `req_ready` bits are 0. All bits are 0 outside IDLE.
- Handshake: `req_valid[i] & req_ready[i]` on a rising edge.
  - The byte is latched into the shift register.
  - `grant_id` takes the value i.
  - `rr_ptr` takes the value (i+1) mod `NUM_REQ`.
  - The baud counter clears, and the FSM moves to START.
- Requesters may drop `req_valid` before acceptance. The decision is re-evaluated every IDLE cycle, with no locking.
- Frame format: start bit 0, then data bits LSB first, then one stop bit 1.
- Baud counter:
  - Width `$clog2(CLKS_PER_BIT)`; counts 0..`CLKS_PER_BIT`-1.
  - Each terminal count advances to the next bit.
  - A 3-bit bit index counts 0..7 in DATA.
- `busy` is high exactly in START, DATA and STOP.
- `Tx` is registered: 1 in IDLE and STOP, 0 in START, shift-register LSB in DATA.
- Reset values (all asserted asynchronously, with reset low):
  - `Tx`=1, `busy`=0, `req_ready`=0, `grant_id`=0.
  - `rr_ptr`=0, state IDLE, counters 0.
- Reset mid-frame: the frame is aborted and `Tx` goes to 1 immediately. No requester is notified, and the byte is lost. After release, arbitration restarts from `rr_ptr`=0.

## Timing
- Latency: `Tx` falls on the edge following the handshake edge.
- Each bit holds for exactly `CLKS_PER_BIT` cycles.
- Frame length from the `Tx` fall to re-entering IDLE: `10*CLKS_PER_BIT` cycles.
- Back-to-back frames:
  - The FSM spends at least one IDLE cycle (`Tx`=1) between frames.
  - The effective stop bit is `CLKS_PER_BIT`+1 cycles.
  - Frame period is `10*CLKS_PER_BIT`+1 cycles.
- `req_ready` is high for exactly one cycle per accepted byte.
- `grant_id` updates on the handshake edge and holds through the frame and the following IDLE.
- No combinational path from `req_data` to any output. Paths from `req_valid` to `req_ready` are combinational.

## Structure
- Shared package `uart_pkg` contains:
  - the `uart_tx_state_t` enum (IDLE, START, DATA, STOP);
  - `UART_DATA_BITS` = 8;
  - `UART_IDLE_LEVEL` = 1'b1.
- One sub-module, `uart_tx_serializer`, handles the baud counter, bit index, shift register, FSM and `Tx`.
  - Inputs: `load`, `load_data`.
  - Outputs: `idle`, `Tx`.
- The top level holds `rr_ptr`, the priority search, `req_ready`, `grant_id` and `busy`.

## Test plan
- Single frame: `CLKS_PER_BIT`=4, requester 0 sends 0xA5.
  - One `req_ready[0]` pulse.
  - `Tx`: 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 for 4 cycles each, then 1.
  - `busy` high for 40 cycles.
- Fairness: all four `req_valid` held high for 5 frames → grant order 0,1,2,3,0. `grant_id` matches each frame.
- Wrap: last grant 3, then only `req_valid[2]` high → requester 2 granted. `rr_ptr` becomes 3.
- Back-to-back: requester 1 continuously valid with 0x00 then 0xFF → `Tx` falls are 41 cycles apart (`CLKS_PER_BIT`=4). Exactly one idle-high cycle is inserted.
- Retraction: `req_valid[1]` pulsed low during IDLE while requester 3 is valid → requester 3 is granted and no frame is sent for 1. `req_ready[1]` never asserts.
- Reset mid-DATA (bit 3 of 0x0F) → `Tx`=1 and `busy`=0 immediately. After release, with requesters 2 and 0 valid, requester 0 is granted first.
